// File: rtl/serial_bus_pkg.sv
// ---------------------------------------------------------------------------
// serial_bus_pkg
// Shared types and elaboration-time helpers for the serial bus port.
//   sb_state_t : TX sequencer states (idle between words / shifting beats)
//   beats()    : number of bus beats needed to move one parallel word
//   ch_w()     : width of a channel index, never narrower than one bit
// ---------------------------------------------------------------------------
package serial_bus_pkg;

    typedef enum logic {
        SB_IDLE  = 1'b0,
        SB_SHIFT = 1'b1
    } sb_state_t;

    function automatic int beats(input int word_w, input int bus_w);
        return word_w / bus_w;
    endfunction

    function automatic int ch_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/serial_bus_port_if.sv
// ---------------------------------------------------------------------------
// serial_bus_port_if
// Bundles the channel-side and external-bus signals of serial_bus_port.
//   slave  modport : view taken by serial_bus_port itself
//   master modport : view taken by whatever drives the port (CPU / bench)
// Signals:
//   tx_load/tx_word/tx_busy          per-channel parallel TX hand-off
//   out_bus/data_out_ready/out_ch    serial TX beat towards the far end
//   ard_receive_ready                far end accepts the current beat
//   shift_done                       last beat of a word accepted
//   in_bus/data_in_ready             serial RX beat from the far end
//   rx_word/rx_valid                 assembled RX word and its update pulse
//   error                            sticky protocol error
// ---------------------------------------------------------------------------
interface serial_bus_port_if #(
    parameter int WORD_W = 16,
    parameter int BUS_W  = 8,
    parameter int NCH    = 3
);
    import serial_bus_pkg::*;

    localparam int CH_W = ch_w(NCH);

    logic [NCH-1:0]        tx_load;
    logic [NCH*WORD_W-1:0] tx_word;
    logic [NCH-1:0]        tx_busy;
    logic [BUS_W-1:0]      out_bus;
    logic                  data_out_ready;
    logic                  ard_receive_ready;
    logic [CH_W-1:0]       out_ch;
    logic                  shift_done;
    logic [BUS_W-1:0]      in_bus;
    logic                  data_in_ready;
    logic [WORD_W-1:0]     rx_word;
    logic                  rx_valid;
    logic                  error;

    modport slave (
        input  tx_load, tx_word, ard_receive_ready, in_bus, data_in_ready,
        output tx_busy, out_bus, data_out_ready, out_ch, shift_done,
               rx_word, rx_valid, error
    );

    modport master (
        output tx_load, tx_word, ard_receive_ready, in_bus, data_in_ready,
        input  tx_busy, out_bus, data_out_ready, out_ch, shift_done,
               rx_word, rx_valid, error
    );

endinterface

// File: rtl/serial_bus_port_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin pick: the first requesting index at or
// after i_ptr, wrapping modulo N.
//   i_req   : request vector
//   i_ptr   : highest-priority index this round
//   o_grant : one-hot grant (all zero when nothing requests)
//   o_idx   : binary index of the grant
//   o_any   : at least one request present
// ---------------------------------------------------------------------------
module rr_arbiter #(
    parameter int N = 3,
    parameter int W = 2
) (
    input  logic [N-1:0] i_req,
    input  logic [W-1:0] i_ptr,
    output logic [N-1:0] o_grant,
    output logic [W-1:0] o_idx,
    output logic         o_any
);

    logic [W-1:0] w_cand;
    logic         w_hit;

    // Walk the requests starting at the pointer; the first hit wins.
    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        w_cand  = '0;
        w_hit   = 1'b0;
        for (int k = 0; k < N; k++) begin
            w_cand          = W'((int'(i_ptr) + k) % N);
            w_hit           = !o_any && i_req[w_cand];
            o_grant[w_cand] = o_grant[w_cand] | w_hit;
            o_idx           = w_hit ? w_cand : o_idx;
            o_any           = o_any | w_hit;
        end
    end

endmodule

// File: rtl/serial_bus_port.sv
// ---------------------------------------------------------------------------
// serial_bus_port
// Owns the single narrow external bus. NCH channels hand over parallel words
// which are serialised most-significant beat first under round-robin
// arbitration; incoming beats are assembled back into words.
//   clk, rst : system clock, synchronous active-high reset
//   bus      : serial_bus_port_if.slave (channel hand-off, TX beat, RX beat)
// TX and RX paths are independent and may run in the same cycle.
// ---------------------------------------------------------------------------
module serial_bus_port #(
    parameter int WORD_W = 16,
    parameter int BUS_W  = 8,
    parameter int NCH    = 3
) (
    input  logic              clk,
    input  logic              rst,
    serial_bus_port_if.slave  bus
);
    import serial_bus_pkg::*;

    localparam int BEATS  = beats(WORD_W, BUS_W);
    localparam int CH_W   = ch_w(NCH);
    localparam int BEAT_W = $clog2(BEATS);

    if (WORD_W % BUS_W != 0) begin : g_chk_multiple
        $error("serial_bus_port: WORD_W must be a multiple of BUS_W");
    end
    if (BEATS < 2) begin : g_chk_beats
        $error("serial_bus_port: a word must span at least two beats");
    end
    if (NCH < 1) begin : g_chk_nch
        $error("serial_bus_port: at least one TX channel is required");
    end

    // TX state
    sb_state_t            r_state;
    sb_state_t            w_state_next;
    logic [WORD_W-1:0]    r_hold [NCH];
    logic [NCH-1:0]       r_busy;
    logic [CH_W-1:0]      r_grant;
    logic [NCH-1:0]       r_grant_oh;
    logic [CH_W-1:0]      r_rr_ptr;
    logic [BEAT_W-1:0]    r_beat;
    logic [WORD_W-1:0]    r_tx_shift;
    logic                 r_error;

    // RX state; the top beat of the shifter is never needed before completion
    logic [WORD_W-BUS_W-1:0] r_rx_shift;
    logic [BEAT_W-1:0]       r_rx_cnt;
    logic [WORD_W-1:0]       r_rx_word;
    logic                    r_rx_valid;

    // Combinational helpers
    logic [NCH-1:0]       w_arb_grant;
    logic [CH_W-1:0]      w_arb_idx;
    logic                 w_arb_any;
    logic                 w_accept;
    logic                 w_last;
    logic [NCH-1:0]       w_clear;
    logic [WORD_W-1:0]    w_rx_next;

    rr_arbiter #(
        .N (NCH),
        .W (CH_W)
    ) u_arb (
        .i_req   (r_busy),
        .i_ptr   (r_rr_ptr),
        .o_grant (w_arb_grant),
        .o_idx   (w_arb_idx),
        .o_any   (w_arb_any)
    );

    // Channel whose final beat is accepted this cycle (frees its holding reg).
    assign w_clear   = r_grant_oh & {NCH{w_last}};
    assign w_rx_next = {r_rx_shift, bus.in_bus};

    // TX sequencer state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= SB_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // TX sequencer next state plus beat-accept / last-beat decode.
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_last       = 1'b0;
        case (r_state)
            SB_IDLE: begin
                if (w_arb_any) begin
                    w_state_next = SB_SHIFT;
                end else begin
                    w_state_next = SB_IDLE;
                end
            end
            SB_SHIFT: begin
                w_accept = bus.ard_receive_ready;
                if (w_accept && (r_beat == BEAT_W'(BEATS - 1))) begin
                    w_last       = 1'b1;
                    w_state_next = SB_IDLE;
                end else begin
                    w_state_next = SB_SHIFT;
                end
            end
            default: begin
                w_state_next = SB_IDLE;
            end
        endcase
    end

    // TX datapath: latch the granted word, shift one beat per accept.
    // The shifter drains to zero, so out_bus reads 0 whenever idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_grant    <= '0;
            r_grant_oh <= '0;
            r_rr_ptr   <= '0;
            r_beat     <= '0;
            r_tx_shift <= '0;
        end else begin
            case (r_state)
                SB_IDLE: begin
                    if (w_arb_any) begin
                        r_grant    <= w_arb_idx;
                        r_grant_oh <= w_arb_grant;
                        r_beat     <= '0;
                        r_tx_shift <= r_hold[w_arb_idx];
                    end else begin
                        r_tx_shift <= '0;
                    end
                end
                SB_SHIFT: begin
                    if (w_accept) begin
                        r_tx_shift <= {r_tx_shift[WORD_W-BUS_W-1:0], {BUS_W{1'b0}}};
                        if (w_last) begin
                            r_beat   <= '0;
                            r_rr_ptr <= (r_grant == CH_W'(NCH - 1)) ? '0 : r_grant + CH_W'(1);
                        end else begin
                            r_beat <= r_beat + BEAT_W'(1);
                        end
                    end else begin
                        r_beat <= r_beat;
                    end
                end
                default: begin
                    r_tx_shift <= '0;
                end
            endcase
        end
    end

    // Channel holding registers, busy flags and the sticky overrun error.
    // A load landing on the cycle the channel's last beat is accepted is legal.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy  <= '0;
            r_error <= 1'b0;
            for (int i = 0; i < NCH; i++) begin
                r_hold[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (bus.tx_load[i] && (!r_busy[i] || w_clear[i])) begin
                    r_hold[i] <= bus.tx_word[i*WORD_W +: WORD_W];
                    r_busy[i] <= 1'b1;
                end else if (w_clear[i]) begin
                    r_busy[i] <= 1'b0;
                end else if (bus.tx_load[i]) begin
                    r_error <= 1'b1;
                end else begin
                    r_busy[i] <= r_busy[i];
                end
            end
        end
    end

    // RX deserialiser: MSB beat first, completion pulses rx_valid for one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_shift <= '0;
            r_rx_cnt   <= '0;
            r_rx_word  <= '0;
            r_rx_valid <= 1'b0;
        end else begin
            r_rx_valid <= 1'b0;
            if (bus.data_in_ready) begin
                r_rx_shift <= w_rx_next[WORD_W-BUS_W-1:0];
                if (r_rx_cnt == BEAT_W'(BEATS - 1)) begin
                    r_rx_word  <= w_rx_next;
                    r_rx_valid <= 1'b1;
                    r_rx_cnt   <= '0;
                end else begin
                    r_rx_cnt <= r_rx_cnt + BEAT_W'(1);
                end
            end else begin
                r_rx_cnt <= r_rx_cnt;
            end
        end
    end

    assign bus.tx_busy        = r_busy;
    assign bus.out_bus        = r_tx_shift[WORD_W-1 -: BUS_W];
    assign bus.data_out_ready = (r_state == SB_SHIFT);
    assign bus.out_ch         = r_grant;
    assign bus.shift_done     = w_last;
    assign bus.rx_word        = r_rx_word;
    assign bus.rx_valid       = r_rx_valid;
    assign bus.error          = r_error;

endmodule

// File: tb/tb_serial_bus_port.sv
// ---------------------------------------------------------------------------
// tb_serial_bus_port
// Directed bench: a 16-bit/8-bit, 3-channel port for TX, RX and error cases,
// plus a 32-bit/8-bit instance for multi-beat RX assembly.
// ---------------------------------------------------------------------------
module tb_serial_bus_port;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    serial_bus_port_if #(.WORD_W(16), .BUS_W(8), .NCH(3)) ifa ();
    serial_bus_port_if #(.WORD_W(32), .BUS_W(8), .NCH(3)) ifb ();

    serial_bus_port #(.WORD_W(16), .BUS_W(8), .NCH(3)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (ifa)
    );

    serial_bus_port #(.WORD_W(32), .BUS_W(8), .NCH(3)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (ifb)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    // Expects one full 16-bit word on port A with ard_receive_ready held high.
    task automatic expect_word(input string tag, input int ch, input logic [15:0] word);
        int waited;
        waited = 0;
        while (ifa.data_out_ready !== 1'b1 && waited < 20) begin
            tick();
            waited++;
        end
        check({tag, " start"}, 64'(ifa.data_out_ready), 64'd1);
        check({tag, " ch"},    64'(ifa.out_ch),         64'(ch));
        check({tag, " hi"},    64'(ifa.out_bus),        64'(word[15:8]));
        check({tag, " done0"}, 64'(ifa.shift_done),     64'd0);
        tick();
        check({tag, " lo"},    64'(ifa.out_bus),        64'(word[7:0]));
        check({tag, " done1"}, 64'(ifa.shift_done),     64'd1);
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        logic [7:0] rx_b [4];
        rx_b = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};

        ifa.tx_load = 3'b000;  ifa.tx_word = '0;  ifa.ard_receive_ready = 1'b0;
        ifa.in_bus  = 8'h00;   ifa.data_in_ready = 1'b0;
        ifb.tx_load = 3'b000;  ifb.tx_word = '0;  ifb.ard_receive_ready = 1'b0;
        ifb.in_bus  = 8'h00;   ifb.data_in_ready = 1'b0;

        // 1: reset dominates loads and RX beats
        rst = 1'b1;
        ifa.tx_load = 3'b111;
        ifa.tx_word = {16'h3333, 16'h2222, 16'h1111};
        ifa.data_in_ready = 1'b1;  ifa.in_bus = 8'h55;
        ifb.data_in_ready = 1'b1;  ifb.in_bus = 8'h55;
        tick();
        tick();
        check("rst busy",  64'(ifa.tx_busy),        64'd0);
        check("rst dor",   64'(ifa.data_out_ready), 64'd0);
        check("rst bus",   64'(ifa.out_bus),        64'd0);
        check("rst ch",    64'(ifa.out_ch),         64'd0);
        check("rst done",  64'(ifa.shift_done),     64'd0);
        check("rst rxv",   64'(ifa.rx_valid),       64'd0);
        check("rst rxw",   64'(ifa.rx_word),        64'd0);
        check("rst err",   64'(ifa.error),          64'd0);
        check("rst b rxv", 64'(ifb.rx_valid),       64'd0);
        rst = 1'b0;
        ifa.tx_load = 3'b000;
        ifa.data_in_ready = 1'b0;
        ifb.data_in_ready = 1'b0;
        tick();
        check("post rst busy", 64'(ifa.tx_busy),        64'd0);
        check("post rst dor",  64'(ifa.data_out_ready), 64'd0);

        // 2: single word on ch0
        ifa.ard_receive_ready = 1'b1;
        ifa.tx_word = {16'h0000, 16'h0000, 16'hBEEF};
        ifa.tx_load = 3'b001;
        tick();
        ifa.tx_load = 3'b000;
        check("single busy", 64'(ifa.tx_busy),        64'd1);
        check("single dor0", 64'(ifa.data_out_ready), 64'd0);
        tick();
        check("single dor1", 64'(ifa.data_out_ready), 64'd1);
        check("single b0",   64'(ifa.out_bus),        64'hBE);
        check("single ch",   64'(ifa.out_ch),         64'd0);
        check("single d0",   64'(ifa.shift_done),     64'd0);
        tick();
        check("single b1",   64'(ifa.out_bus),        64'hEF);
        check("single d1",   64'(ifa.shift_done),     64'd1);
        check("single bsy1", 64'(ifa.tx_busy),        64'd1);
        tick();
        check("single bsy0", 64'(ifa.tx_busy),        64'd0);
        check("single idle", 64'(ifa.data_out_ready), 64'd0);
        check("single bus0", 64'(ifa.out_bus),        64'd0);

        // 3: round robin from ch0, then reload ch0/ch1 while ch2 shifts
        do_reset();
        ifa.tx_word = {16'h3333, 16'h2222, 16'h1111};
        ifa.tx_load = 3'b111;
        tick();
        ifa.tx_load = 3'b000;
        check("rr busy", 64'(ifa.tx_busy), 64'd7);
        expect_word("rr0", 0, 16'h1111);
        expect_word("rr1", 1, 16'h2222);
        tick();
        check("rr2 ch", 64'(ifa.out_ch),  64'd2);
        check("rr2 hi", 64'(ifa.out_bus), 64'h33);
        ifa.tx_word = {16'h0000, 16'h5A5A, 16'hA5A5};
        ifa.tx_load = 3'b011;
        tick();
        ifa.tx_load = 3'b000;
        check("rr2 lo",   64'(ifa.out_bus),    64'h33);
        check("rr2 done", 64'(ifa.shift_done), 64'd1);
        check("rr2 busy", 64'(ifa.tx_busy),    64'd7);
        tick();
        check("rr2 busy after", 64'(ifa.tx_busy), 64'd3);
        check("rr2 err",        64'(ifa.error),   64'd0);
        expect_word("rr3", 0, 16'hA5A5);
        expect_word("rr4", 1, 16'h5A5A);
        check("rr end busy", 64'(ifa.tx_busy), 64'd0);

        // 4: backpressure on beat 0, then a legal reload on the last beat
        ifa.ard_receive_ready = 1'b0;
        ifa.tx_word = {16'h0000, 16'h0000, 16'hBEEF};
        ifa.tx_load = 3'b001;
        tick();
        ifa.tx_load = 3'b000;
        tick();
        for (int k = 0; k < 3; k++) begin
            check("bp hold bus", 64'(ifa.out_bus),    64'hBE);
            check("bp no done",  64'(ifa.shift_done), 64'd0);
            tick();
        end
        check("bp ch", 64'(ifa.out_ch), 64'd0);
        ifa.ard_receive_ready = 1'b1;
        check("bp rel bus",  64'(ifa.out_bus),    64'hBE);
        check("bp rel done", 64'(ifa.shift_done), 64'd0);
        tick();
        check("bp lo",   64'(ifa.out_bus),    64'hEF);
        check("bp done", 64'(ifa.shift_done), 64'd1);
        ifa.tx_word = {16'h0000, 16'h0000, 16'h0F0F};
        ifa.tx_load = 3'b001;
        tick();
        ifa.tx_load = 3'b000;
        check("reload err",  64'(ifa.error),          64'd0);
        check("reload busy", 64'(ifa.tx_busy),        64'd1);
        check("reload idle", 64'(ifa.data_out_ready), 64'd0);
        expect_word("reload", 0, 16'h0F0F);

        // 5: RX with a gap, and 32-bit assembly on port B
        ifa.data_in_ready = 1'b1;  ifa.in_bus = 8'hCA;
        tick();
        ifa.data_in_ready = 1'b0;
        check("rx mid valid", 64'(ifa.rx_valid), 64'd0);
        tick();
        tick();
        check("rx gap valid", 64'(ifa.rx_valid), 64'd0);
        ifa.data_in_ready = 1'b1;  ifa.in_bus = 8'hFE;
        tick();
        ifa.data_in_ready = 1'b0;
        check("rx valid", 64'(ifa.rx_valid), 64'd1);
        check("rx word",  64'(ifa.rx_word),  64'hCAFE);
        tick();
        check("rx valid off", 64'(ifa.rx_valid), 64'd0);
        check("rx word held", 64'(ifa.rx_word),  64'hCAFE);
        for (int k = 0; k < 4; k++) begin
            ifb.data_in_ready = 1'b1;
            ifb.in_bus = rx_b[k];
            tick();
            if (k < 3) begin
                check("rx32 early valid", 64'(ifb.rx_valid), 64'd0);
            end
        end
        ifb.data_in_ready = 1'b0;
        check("rx32 valid", 64'(ifb.rx_valid), 64'd1);
        check("rx32 word",  64'(ifb.rx_word),  64'hDEADBEEF);
        tick();
        check("rx32 valid off", 64'(ifb.rx_valid), 64'd0);

        // 6: overrun load sets sticky error; reset mid-word clears everything
        ifa.ard_receive_ready = 1'b0;
        ifa.tx_word = {16'h0000, 16'h1234, 16'h0000};
        ifa.tx_load = 3'b010;
        tick();
        ifa.tx_load = 3'b000;
        check("err busy", 64'(ifa.tx_busy), 64'd2);
        check("err pre",  64'(ifa.error),   64'd0);
        ifa.tx_word = {16'h0000, 16'hFFFF, 16'h0000};
        ifa.tx_load = 3'b010;
        tick();
        ifa.tx_load = 3'b000;
        check("err set", 64'(ifa.error), 64'd1);
        tick();
        check("err sticky", 64'(ifa.error), 64'd1);
        ifa.ard_receive_ready = 1'b1;
        check("err word hi", 64'(ifa.out_bus), 64'h12);
        check("err ch",      64'(ifa.out_ch),  64'd1);
        tick();
        check("err word lo", 64'(ifa.out_bus),    64'h34);
        check("err done",    64'(ifa.shift_done), 64'd1);
        tick();
        check("err still", 64'(ifa.error),   64'd1);
        check("err idle",  64'(ifa.tx_busy), 64'd0);
        ifa.tx_word = {16'hABCD, 16'h0000, 16'h0000};
        ifa.tx_load = 3'b100;
        tick();
        ifa.tx_load = 3'b000;
        tick();
        check("mid hi", 64'(ifa.out_bus), 64'hAB);
        tick();
        check("mid lo", 64'(ifa.out_bus), 64'hCD);
        do_reset();
        check("mid rst dor",  64'(ifa.data_out_ready), 64'd0);
        check("mid rst bus",  64'(ifa.out_bus),        64'd0);
        check("mid rst err",  64'(ifa.error),          64'd0);
        check("mid rst busy", 64'(ifa.tx_busy),        64'd0);
        ifa.tx_word = {16'h9876, 16'h0000, 16'h0000};
        ifa.tx_load = 3'b100;
        tick();
        ifa.tx_load = 3'b000;
        expect_word("post rst", 2, 16'h9876);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
